cache_line_burst_adaptor: RTL and testbench

- Memory-side end of the cache data path: moves whole 256-bit cache lines between the cache datapath and the 64-bit burst memory interface.
- Fill: collects 4 memory beats into one line for the cache.
- Writeback: serialises a dirty line into 4 beats.
- Sits between cache control/datapath and physical memory (or the arbiter), opposite the word-merge logic that edits lines in place.

---
 rtl/cache_line_burst_adaptor.sv | 152 +++++++++++++++
 tb/tb_cache_line_burst_adaptor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_burst_adaptor.sv
// cache_line_burst_adaptor
// Moves whole cache lines between the cache datapath and a narrower burst
// memory port. A fill gathers BEATS memory beats into one line. A writeback
// serialises a latched line into BEATS beats.
//
// Optional build macro BURST_TIMEOUT_EN adds a per-burst watchdog. When the
// watchdog expires, the burst is aborted and err_o pulses alongside resp_o.
// Without the macro, err_o is tied low and a burst waits on resp_i forever.
//
// Handshake rules:
//   Cache side:
//     - read_i/write_i are level requests.
//     - A request is accepted on the first rising edge that sees it in IDLE.
//     - The requester holds the request and address_i until the resp_o cycle.
//     - resp_o is a one-cycle completion pulse.
//   Memory side:
//     - read_o/write_o stay high for the whole burst and act as valid.
//     - Every cycle with resp_i=1 transfers exactly one beat, so resp_i acts as ready.
//     - Cycles with resp_i=0 are wait states.

module cache_line_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i,
    output logic              err_o
);

    localparam int         BEATS     = LINE_W / BURST_W;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        beat;
    logic [LINE_W-1:0] line_q;
    logic [31:0]       addr_q;
    logic              abort;

    assign address_o = addr_q;

`ifdef BURST_TIMEOUT_EN
    logic [7:0] wd;
    logic       aborted;

    // The watchdog counts consecutive wait states inside a burst.
    // An expiry marks the burst as aborted so DONE can flag err_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            aborted <= 1'b0;
        end else begin
            if (state == IDLE || state == DONE || resp_i) wd <= '0;
            else                                          wd <= wd + 8'd1;
            if (state == IDLE)  aborted <= 1'b0;
            else if (abort)     aborted <= 1'b1;
        end
    end

    assign abort = (state == RD || state == WR) && !resp_i && (wd == 8'(TIMEOUT));
    assign err_o = (state == DONE) && aborted;
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and output decode. A write request wins when both requests are high.
    always_comb begin
        state_next = state;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        burst_o    = '0;
        case (state)
            IDLE: begin
                if (write_i)     state_next = WR;
                else if (read_i) state_next = RD;
            end
            RD: begin
                read_o = 1'b1;
                if (abort || (resp_i && beat == LAST_BEAT)) state_next = DONE;
            end
            WR: begin
                write_o = 1'b1;
                burst_o = line_q[beat*BURST_W +: BURST_W];
                if (abort || (resp_i && beat == LAST_BEAT)) state_next = DONE;
            end
            DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the request on accept, then place or step through beats on each ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat   <= '0;
            line_q <= '0;
            addr_q <= '0;
            line_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (write_i) begin
                        line_q <= line_i;
                        addr_q <= address_i & LINE_MASK;
                    end else if (read_i) begin
                        addr_q <= address_i & LINE_MASK;
                        line_o <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_o[beat*BURST_W +: BURST_W] <= burst_i;
                        beat <= beat + 2'd1;
                    end
                end
                WR: begin
                    if (resp_i) beat <= beat + 2'd1;
                end
                DONE: beat <= '0;
                default: beat <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_burst_adaptor.sv
// Bench for cache_line_burst_adaptor.
// Combines directed scenarios with randomized bursts, all checked against a line/beat model.
// The expected line is assembled from the beats actually sent.
// The expected writeback beats are sliced from the line that was handed over.
module tb_cache_line_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
    logic         err_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    cache_line_burst_adaptor #(.LINE_W(256), .BURST_W(64), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i), .err_o(err_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] nib_beat(input int n);
        logic [3:0] nib;
        nib = 4'(n);
        return {16{nib}};
    endfunction

    // Fill: optional initial stall, then 4 beats.
    // Gaps come from pat (LSB first) when use_pat is set, otherwise from $urandom.
    task automatic run_fill(input logic [31:0] addr, input logic [7:0] pat, input bit use_pat,
                            input int stall, input bit fixed);
        logic [63:0]  beats[$];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        int sent, iter, gap_run;
        bit r;
        exp_addr = {addr[31:5], 5'b0};
        read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check("fill_read_o_rise", read_o, 1);
        check("fill_address_o", address_o, exp_addr);
        check("fill_line_cleared", line_o, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_read_o", read_o, 1);
            check("stall_err_o", err_o, 0);
            check("stall_resp_o", resp_o, 0);
        end
        sent = 0; iter = 0; gap_run = 0;
        while (sent < 4 && iter < 200) begin
            check("fill_resp_o_early", resp_o, 0);
            check("fill_read_o_hold", read_o, 1);
            check("fill_address_hold", address_o, exp_addr);
            if (use_pat) r = (iter < 8) ? pat[iter] : 1'b1;
            else         r = ($urandom_range(0, 2) != 0) || (gap_run >= 3);
            gap_run = r ? 0 : gap_run + 1;
            resp_i  = r;
            burst_i = fixed ? nib_beat(sent + 1) : {$urandom, $urandom};
            if (r) begin
                beats.push_back(burst_i);
                sent++;
            end
            iter++;
            @(negedge clk);
        end
        resp_i = 1'b0;
        check("fill_budget", sent, 4);
        exp_line = '0;
        for (int j = 0; j < beats.size(); j++) exp_line = exp_line | (256'(beats[j]) << (64 * j));
        check("fill_resp_o", resp_o, 1);
        check("fill_read_o_drop", read_o, 0);
        check("fill_err_o", err_o, 0);
        check("fill_line_o", line_o, exp_line);
        read_i = 1'b0;
        @(negedge clk);
        check("fill_resp_o_single", resp_o, 0);
        check("fill_line_o_held", line_o, exp_line);
    endtask

    // Writeback. The expected beat sequence is the line sliced into 64-bit chunks, low chunk first.
    task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input logic [7:0] pat,
                             input bit use_pat, input bit also_read, input bit stray_read);
        logic [31:0] exp_addr;
        int iter, gap_run;
        bit r;
        exp_addr = {addr[31:5], 5'b0};
        exp_q.delete();
        for (int j = 0; j < 4; j++) exp_q.push_back(64'(line >> (64 * j)));
        write_i = 1'b1; read_i = also_read; line_i = line; address_i = addr; resp_i = 1'b0;
        @(posedge clk); @(negedge clk);
        line_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        iter = 0; gap_run = 0;
        while (exp_q.size() > 0 && iter < 200) begin
            check("wr_write_o", write_o, 1);
            check("wr_read_o", read_o, 0);
            check("wr_resp_o_early", resp_o, 0);
            check("wr_burst_o", burst_o, exp_q[0]);
            check("wr_address_o", address_o, exp_addr);
            if (use_pat) r = (iter < 8) ? pat[iter] : 1'b1;
            else         r = ($urandom_range(0, 2) != 0) || (gap_run >= 3);
            gap_run = r ? 0 : gap_run + 1;
            resp_i = r;
            if (stray_read) read_i = 1'($urandom_range(0, 1));
            if (r) void'(exp_q.pop_front());
            iter++;
            @(negedge clk);
        end
        resp_i = 1'b0;
        check("wr_budget", exp_q.size(), 0);
        check("wr_resp_o", resp_o, 1);
        check("wr_write_o_drop", write_o, 0);
        check("wr_read_o_none", read_o, 0);
        check("wr_err_o", err_o, 0);
        write_i = 1'b0; read_i = 1'b0;
        @(negedge clk);
        check("wr_resp_o_single", resp_o, 0);
        check("wr_idle_read_o", read_o, 0);
        check("wr_idle_write_o", write_o, 0);
    endtask

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_resp_o", resp_o, 0);
        check("rst_err_o", err_o, 0);
        check("rst_line_o", line_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_address_o", address_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill with back-to-back beats 0x1111.. through 0x4444.. at address 0x1234.
        run_fill(32'h0000_1234, 8'hFF, 1'b1, 0, 1'b1);

        // Writeback of {D,C,B,A} with ack pattern 1,0,0,1,1,0,1.
        run_write(32'h0000_5678, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
                  8'h59, 1'b1, 1'b0, 1'b0);

        // Both requests at once: the write wins.
        run_write(32'hABCD_EF17, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  8'hFF, 1'b1, 1'b1, 1'b0);

        // Reset after two fill beats.
        read_i = 1'b1; address_i = 32'h0000_0440;
        @(posedge clk); @(negedge clk);
        resp_i = 1'b1; burst_i = {$urandom, $urandom};
        @(negedge clk);
        burst_i = {$urandom, $urandom};
        @(negedge clk);
        resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
        @(negedge clk);
        check("midrst_read_o", read_o, 0);
        check("midrst_resp_o", resp_o, 0);
        check("midrst_line_o", line_o, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_resp", resp_o, 0);
            check("midrst_idle_read_o", read_o, 0);
        end
        run_fill(32'h0000_0460, 8'hFF, 1'b1, 0, 1'b1);

        // Stray acks in IDLE must not move the beat count.
        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            check("stray_read_o", read_o, 0);
            check("stray_write_o", write_o, 0);
            check("stray_resp_o", resp_o, 0);
        end
        resp_i = 1'b0;
        run_fill(32'h1000_003F, 8'hFF, 1'b1, 0, 1'b1);

        // Read pulses during a writeback are ignored.
        run_write(32'h2000_0000, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  8'h00, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) != 0)
                run_fill($urandom, 8'h00, 1'b0, 0, 1'b0);
            else
                run_write($urandom, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                          8'h00, 1'b0, 1'b0, 1'b0);
        end

`ifdef BURST_TIMEOUT_EN
        // A fill with no acks aborts after the watchdog expires.
        read_i = 1'b1; address_i = 32'h0000_0800;
        @(posedge clk); @(negedge clk);
        for (int t = 0; t < 17; t++) begin
            check("to_read_o_wait", read_o, 1);
            check("to_resp_o_early", resp_o, 0);
            check("to_err_o_early", err_o, 0);
            @(negedge clk);
        end
        check("to_resp_o", resp_o, 1);
        check("to_err_o", err_o, 1);
        check("to_read_o_drop", read_o, 0);
        read_i = 1'b0;
        @(negedge clk);
        check("to_after_read_o", read_o, 0);
        check("to_after_err_o", err_o, 0);
        check("to_after_resp_o", resp_o, 0);
`else
        // Without the watchdog, a burst simply waits for its acks.
        run_fill(32'h0000_0800, 8'h00, 1'b0, 40, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
